// File: rtl/multicycle_controller_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_controller_pkg : state, opcode/funct and ALU control encodings
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_RWB    = 4'd7,
        S_EXEC_I = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if : instruction fields, status and datapath controls
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface multicycle_controller_if;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        MemtoReg;
    logic        RegDst;
    logic        RegWrite;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        PCSource;
    logic [3:0]  ALU_Control;
    logic        instr_done;
    logic        illegal;
    logic [31:0] retired;

    // master = control unit, slave = datapath / environment
    modport master (
        input  opcode, funct, zero, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               ALU_Control, instr_done, illegal, retired
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               ALU_Control, instr_done, illegal, retired
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_controller_alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder : R-type funct field to ALU control code, with a valid flag
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_control,
    output logic       o_valid
);

    always_comb begin
        o_alu_control = ALU_ADD;
        o_valid       = 1'b1;
        case (i_funct)
            FN_ADD:  o_alu_control = ALU_ADD;
            FN_SUB:  o_alu_control = ALU_SUB;
            FN_AND:  o_alu_control = ALU_AND;
            FN_OR:   o_alu_control = ALU_OR;
            FN_SLT:  o_alu_control = ALU_SLT;
            FN_NOR:  o_alu_control = ALU_NOR;
            default: o_valid       = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller : Moore control FSM for a multicycle MIPS-subset core
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_controller_if.master bus
);

    state_e      state_q, state_d;
    logic        instr_done_q, instr_done_d;
    logic        illegal_q, illegal_d;
    logic [31:0] retired_q, retired_d;
    logic [3:0]  w_fn_alu;
    logic        w_fn_valid;

    alu_decoder u_alu_decoder (
        .i_funct       (bus.funct),
        .o_alu_control (w_fn_alu),
        .o_valid       (w_fn_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            instr_done_q <= 1'b0;
            illegal_q    <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            instr_done_q <= instr_done_d;
            illegal_q    <= illegal_d;
            retired_q    <= retired_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        instr_done_d     = 1'b0;
        illegal_d        = 1'b0;
        bus.PCWrite      = 1'b0;
        bus.PCWriteCond  = 1'b0;
        bus.IorD         = 1'b0;
        bus.MemRead      = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.IRWrite      = 1'b0;
        bus.MemtoReg     = 1'b0;
        bus.RegDst       = 1'b0;
        bus.RegWrite     = 1'b0;
        bus.ALUSrcA      = 1'b0;
        bus.ALUSrcB      = SRCB_REGB;
        bus.PCSource     = 1'b0;
        bus.ALU_Control  = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = SRCB_FOUR;
                // Mealy strobes; reset holds the state in FETCH, so gate them too
                bus.IRWrite = bus.mem_ready & rst_n;
                bus.PCWrite = bus.mem_ready & rst_n;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.ALUSrcB = SRCB_IMM_SL2;
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_BEQ:       state_d = S_BRANCH;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
                state_d     = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
                state_d      = S_FETCH;
                instr_done_d = 1'b1;
            end
            S_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                if (bus.mem_ready) begin
                    state_d      = S_FETCH;
                    instr_done_d = 1'b1;
                end
            end
            S_EXEC_R: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUSrcB     = SRCB_REGB;
                bus.ALU_Control = w_fn_alu;
                if (w_fn_valid) begin
                    state_d = S_RWB;
                end else begin
                    state_d   = S_FETCH;
                    illegal_d = 1'b1;
                end
            end
            S_RWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
                state_d      = S_FETCH;
                instr_done_d = 1'b1;
            end
            S_EXEC_I: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
                state_d     = S_IWB;
            end
            S_IWB: begin
                bus.RegWrite = 1'b1;
                state_d      = S_FETCH;
                instr_done_d = 1'b1;
            end
            S_BRANCH: begin
                // ALUOut already holds the target computed in DECODE
                bus.ALUSrcA     = 1'b1;
                bus.ALUSrcB     = SRCB_REGB;
                bus.ALU_Control = ALU_SUB;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 1'b1;
                state_d         = S_FETCH;
                instr_done_d    = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        retired_d = retired_q + {31'd0, instr_done_d};
    end

    assign bus.instr_done = instr_done_q;
    assign bus.illegal    = illegal_q;
    assign bus.retired    = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller : directed cases plus random instruction stream
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_controller;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb;
        logic       pcsrc;
        logic [3:0] alu;
    } ctl_t;

    // Steps an instruction walks through; waits consume mem_ready
    localparam int PH_FETCH = 0, PH_DECODE = 1, PH_ADDR = 2, PH_RDWAIT = 3,
                   PH_LOADWB = 4, PH_WRWAIT = 5, PH_ALU_R = 6, PH_REGWB_R = 7,
                   PH_ALU_I = 8, PH_REGWB_I = 9, PH_BRANCH = 10;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          plan[$];
    logic        exp_done = 1'b0;
    logic        exp_ill  = 1'b0;
    logic [31:0] exp_retired = '0;
    int          fetch_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [4:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 5'b1_0010;
            6'b100010: return 5'b1_0110;
            6'b100100: return 5'b1_0000;
            6'b100101: return 5'b1_0001;
            6'b101010: return 5'b1_0111;
            6'b100111: return 5'b1_1100;
            default:   return 5'b0_0010;
        endcase
    endfunction

    function automatic ctl_t expect_ctl(input int ph, input logic mr, input logic [5:0] fn);
        ctl_t e;
        logic [4:0] a;
        e = '0;
        e.alu = 4'b0010;
        a = r_alu(fn);
        case (ph)
            PH_FETCH:   begin e.mrd = 1; e.srcb = 2'b01; e.irw = mr; e.pcw = mr; end
            PH_DECODE:  e.srcb = 2'b11;
            PH_ADDR:    begin e.srca = 1; e.srcb = 2'b10; end
            PH_RDWAIT:  begin e.mrd = 1; e.iord = 1; end
            PH_LOADWB:  begin e.m2r = 1; e.rw = 1; end
            PH_WRWAIT:  begin e.mwr = 1; e.iord = 1; end
            PH_ALU_R:   begin e.srca = 1; e.alu = a[3:0]; end
            PH_REGWB_R: begin e.rdst = 1; e.rw = 1; end
            PH_ALU_I:   begin e.srca = 1; e.srcb = 2'b10; end
            PH_REGWB_I: e.rw = 1;
            PH_BRANCH:  begin e.srca = 1; e.alu = 4'b0110; e.pcwc = 1; e.pcsrc = 1; end
            default:    e = '0;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin : compare
        ctl_t act;
        int   ph;
        logic nd, ni;
        logic [4:0] a;
        if (!rst_n) begin
            check("reset_instr_done", {31'd0, bus.instr_done}, 0);
            check("reset_illegal", {31'd0, bus.illegal}, 0);
            check("reset_retired", bus.retired, 0);
            check("reset_no_writes", {29'd0, bus.RegWrite, bus.MemWrite, bus.PCWrite}, 0);
            plan.delete();
            plan.push_back(PH_FETCH);
            exp_done = 0; exp_ill = 0; exp_retired = '0;
        end else begin
            if (plan.size() == 0) plan.push_back(PH_FETCH);
            ph  = plan.pop_front();
            act = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                   bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                   bus.ALUSrcB, bus.PCSource, bus.ALU_Control};
            check($sformatf("ctl_ph%0d", ph), {15'd0, act}, {15'd0, expect_ctl(ph, bus.mem_ready, bus.funct)});
            check("instr_done", {31'd0, bus.instr_done}, {31'd0, exp_done});
            check("illegal", {31'd0, bus.illegal}, {31'd0, exp_ill});
            check("retired", bus.retired, exp_retired);
            check("memwrite_regwrite_excl", {31'd0, bus.MemWrite & bus.RegWrite}, 0);
            check("memread_memwrite_excl", {31'd0, bus.MemRead & bus.MemWrite}, 0);
            nd = 0; ni = 0;
            a  = r_alu(bus.funct);
            case (ph)
                PH_FETCH: if (bus.mem_ready) begin
                    plan.push_back(PH_DECODE);
                    fetch_count++;
                end else plan.push_front(PH_FETCH);
                PH_DECODE: case (bus.opcode)
                    6'b000000: begin plan.push_back(PH_ALU_R); plan.push_back(PH_REGWB_R); end
                    6'b100011: begin plan.push_back(PH_ADDR); plan.push_back(PH_RDWAIT); plan.push_back(PH_LOADWB); end
                    6'b101011: begin plan.push_back(PH_ADDR); plan.push_back(PH_WRWAIT); end
                    6'b001000: begin plan.push_back(PH_ALU_I); plan.push_back(PH_REGWB_I); end
                    6'b000100: plan.push_back(PH_BRANCH);
                    default:   ni = 1;
                endcase
                PH_ALU_R: if (!a[4]) begin ni = 1; plan.delete(); end
                PH_RDWAIT: if (!bus.mem_ready) plan.push_front(ph);
                PH_WRWAIT: if (!bus.mem_ready) plan.push_front(ph); else nd = 1;
                PH_LOADWB, PH_REGWB_R, PH_REGWB_I, PH_BRANCH: nd = 1;
                default: ;
            endcase
            if (plan.size() == 0) plan.push_back(PH_FETCH);
            exp_done = nd;
            exp_ill  = ni;
            exp_retired = exp_retired + {31'd0, nd};
        end
    end

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    initial begin
        int last_fc;
        int r;
        rst_n = 0;
        bus.opcode = 6'b000000; bus.funct = 6'b100000; bus.zero = 0; bus.mem_ready = 1;
        #2;
        check("por_retired", bus.retired, 0);
        check("por_instr_done", {31'd0, bus.instr_done}, 0);
        check("por_illegal", {31'd0, bus.illegal}, 0);
        check("por_fetch_memread", {31'd0, bus.MemRead}, 1);
        check("por_pcwrite_gated", {31'd0, bus.PCWrite}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;

        // add $3,$1,$2
        mid(); check("add_c1_irwrite_pcwrite", {30'd0, bus.IRWrite, bus.PCWrite}, 3); cyc();
        mid(); check("add_c2_srcb", {30'd0, bus.ALUSrcB}, 3); cyc();
        mid(); check("add_c3_srca_alu", {27'd0, bus.ALUSrcA, bus.ALU_Control}, 5'b10010); cyc();
        mid(); check("add_c4_wb", {29'd0, bus.RegWrite, bus.RegDst, bus.MemtoReg}, 3'b110);
               check("add_c4_retired", bus.retired, 0); cyc();

        // lw with two stalled MEMRD cycles
        bus.opcode = 6'b100011;
        for (int c = 1; c <= 7; c++) begin
            bus.mem_ready = (c == 4 || c == 5) ? 1'b0 : 1'b1;
            mid();
            if (c == 1) begin
                check("add_done", {31'd0, bus.instr_done}, 1);
                check("add_retired", bus.retired, 1);
            end
            check($sformatf("lw_c%0d_memtoreg_regwrite", c), {30'd0, bus.MemtoReg, bus.RegWrite},
                  (c == 7) ? 32'd3 : 32'd0);
            cyc();
        end

        // beq
        bus.opcode = 6'b000100; bus.mem_ready = 1; bus.zero = 0;
        mid(); check("lw_done", {31'd0, bus.instr_done}, 1); check("lw_retired", bus.retired, 2); cyc();
        mid(); check("beq_c2_no_branch", {26'd0, bus.PCWriteCond, bus.PCSource, bus.ALU_Control}, 6'b000010); cyc();
        mid(); check("beq_c3_branch", {26'd0, bus.PCWriteCond, bus.PCSource, bus.ALU_Control}, 6'b110110); cyc();

        // illegal opcode
        bus.opcode = 6'b111111;
        mid(); check("beq_done", {31'd0, bus.instr_done}, 1); check("beq_retired", bus.retired, 3); cyc();
        mid(); check("beq_done_once", {31'd0, bus.instr_done}, 0); cyc();
        bus.opcode = 6'b101011;
        mid(); check("ill_pulse", {31'd0, bus.illegal}, 1);
               check("ill_retired", bus.retired, 3);
               check("ill_no_writes", {29'd0, bus.RegWrite, bus.MemWrite, bus.PCWriteCond}, 0);
               check("ill_in_fetch", {31'd0, bus.MemRead}, 1); cyc();

        // sw interrupted by reset in MEMWR
        mid(); check("ill_pulse_once", {31'd0, bus.illegal}, 0); cyc();
        mid(); check("sw_memadr_srcb", {30'd0, bus.ALUSrcB}, 2); cyc();
        bus.mem_ready = 0;
        mid(); check("sw_memwrite", {30'd0, bus.MemWrite, bus.IorD}, 3);
        #1 rst_n = 0;
        #1;
        check("rst_async_memwrite", {31'd0, bus.MemWrite}, 0);
        check("rst_async_retired", bus.retired, 0);
        check("rst_async_fetch", {31'd0, bus.MemRead}, 1);
        bus.mem_ready = 1;
        cyc();
        mid(); check("rst_hold_no_writes", {29'd0, bus.RegWrite, bus.MemWrite, bus.PCWrite}, 0); cyc();
        rst_n = 1;

        // addi with retired preloaded to all ones
        bus.opcode = 6'b001000;
        force dut.retired_q = 32'hFFFF_FFFF;
        exp_retired = 32'hFFFF_FFFF;
        mid(); check("wrap_preload", bus.retired, 32'hFFFF_FFFF); cyc();
        mid(); release dut.retired_q; cyc();
        mid(); cyc();
        mid(); check("addi_wb", {30'd0, bus.RegWrite, bus.RegDst}, 2); cyc();
        mid(); check("wrap_retired", bus.retired, 0); check("wrap_done", {31'd0, bus.instr_done}, 1); cyc();

        // random instruction stream; IR fields change only once a fetch completes
        last_fc = fetch_count;
        for (int c = 0; c < 4000; c++) begin
            if (!rst_n) rst_n = 1;
            else if ($urandom_range(0, 299) == 0) rst_n = 0;
            if (fetch_count != last_fc) begin
                last_fc = fetch_count;
                r = $urandom_range(0, 9);
                case (r)
                    0, 1, 2: bus.opcode = 6'b000000;
                    3:       bus.opcode = 6'b100011;
                    4:       bus.opcode = 6'b101011;
                    5:       bus.opcode = 6'b001000;
                    6:       bus.opcode = 6'b000100;
                    default: bus.opcode = 6'($urandom_range(0, 63));
                endcase
                case ($urandom_range(0, 7))
                    0: bus.funct = 6'b100000;
                    1: bus.funct = 6'b100010;
                    2: bus.funct = 6'b100100;
                    3: bus.funct = 6'b100101;
                    4: bus.funct = 6'b101010;
                    5: bus.funct = 6'b100111;
                    default: bus.funct = 6'($urandom_range(0, 63));
                endcase
            end
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            bus.zero = 1'($urandom_range(0, 1));
            cyc();
        end
        rst_n = 1;
        mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
